// File: rtl/subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width rule.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so the counter can hold N itself without wrapping, even for N=1.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit combinational subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit unsigned subtractor, LSB first, start/busy/done handshake.
// diff/underflow are updated only on the completion edge and held until the next one.
module serial_subtractor_nbit
    import subtractor_pkg::*;
#(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 underflow
);

    localparam int             CW   = cnt_width(BIT_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(BIT_WIDTH - 1);

    state_t               state, state_nx;
    logic [CW-1:0]        count;
    logic [BIT_WIDTH-1:0] a_sh, b_sh, part, part_nx;
    logic                 br;
    logic                 d_bit, br_nx;
    logic                 accept, last;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nx)
    );

    // Difference bits enter at the MSB so that after N shifts bit 0 sits at the LSB.
    assign part_nx = (part >> 1) | (BIT_WIDTH'(d_bit) << (BIT_WIDTH - 1));
    assign last    = (count == LAST);
    assign accept  = start && (state == IDLE || state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            part      <= '0;
            br        <= 1'b0;
            diff      <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                br    <= borrow_in;
                count <= '0;
            end else if (state == SHIFT) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                br    <= br_nx;
                part  <= part_nx;
                count <= count + 1'b1;
                if (last) begin
                    diff      <= part_nx;
                    underflow <= br_nx;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
